uart_cmd_rx: RTL
================

# uart_cmd_rx

Receive side of the host command link: deserializes 8N1 UART frames arriving on the Segway's RX pin from the BLE module and decodes single-byte commands into a registered power-enable. Sits inside the Segway top level between the RX pad and the balance/steer control, and is the counterpart of the command transmitter used to drive RX in the system bench. Owns the 'g' (go) / 's' (stop) authorization state, so power drops only once the rider has stepped off.

## Interface
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); must be ≥ 16
- CMD_GO, 8'h67, ASCII 'g': power-up command
- CMD_STOP, 8'h73, ASCII 's': power-down request
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- RX  in  1  serial input, idle high, asynchronous to clk
- rider_off  in  1  high when load cells report no rider (synchronous to clk)
- rx_data  out  8  last received byte, held until the next valid frame
- rx_rdy  out  1  sticky: high from a valid frame until clr_rdy or the next start bit
- clr_rdy  in  1  one-cycle clear of rx_rdy
- frm_err  out  1  one-cycle pulse: stop bit sampled low
- pwr_up  out  1  power enable to the motor drive

## Operation
- RX passes through a two-flop synchronizer, reset to 1. Start detect is a falling edge on the synchronized signal while the receiver is IDLE.
- Receiver states: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: count BAUD_DIV/2 (integer division), then resample. If low, go to DATA. If high, treat as a glitch and return to IDLE with no flags.
  - DATA: sample every BAUD_DIV cycles, 8 samples, LSB first into a shift register.
  - STOP: one more BAUD_DIV. If the sample is high, load rx_data and set rx_rdy. If low, pulse frm_err, leave rx_data and rx_rdy unchanged, and issue no command.
- rx_rdy is cleared by clr_rdy or by the next start detect. A set and a clear in the same cycle resolve as set.
- Bit counter is 4 bits; baud counter is $clog2(BAUD_DIV) bits, reloaded at every transition.
- The auth FSM acts on the one-cycle internal valid pulse from the receiver, not on rx_rdy. Unrecognized bytes are ignored.
  - OFF: CMD_GO -> PWR1.
  - PWR1: CMD_STOP with rider_off=1 -> OFF. CMD_STOP with rider_off=0 -> PWR2.
  - PWR2: CMD_GO -> PWR1. rider_off=1 -> OFF.
- pwr_up is registered and high in PWR1 and PWR2.
- Reset, including mid-frame: receiver to IDLE, FSM to OFF, rx_data=0, rx_rdy=0, frm_err=0, pwr_up=0, synchronizer=1. The frame in progress is discarded.

## Timing
- Sample point for bit n (start=0, d0..d7=1..8, stop=9): BAUD_DIV/2 + n·BAUD_DIV cycles after the synchronized falling edge.
- The synchronizer adds 2 cycles of latency after the RX pin edge.
- rx_rdy, rx_data and frm_err update on the cycle after the stop sample.
- pwr_up changes on the cycle after rx_rdy rises, or 1 cycle after rider_off rises while in PWR2.
- Back-to-back frames need no idle gap. The receiver returns to IDLE right after the stop sample, which is mid stop bit, so the next start edge is caught.
- Tolerates ±4% baud mismatch.

## Structure
- Package uart_cmd_pkg holds the CMD_GO/CMD_STOP defaults and typedef enums rx_state_t {IDLE,START,DATA,STOP} and auth_state_t {OFF,PWR1,PWR2}.
- Sub-module uart_rx implements the synchronizer, baud/bit counters, shifter and rx_rdy/frm_err, and is reusable elsewhere.
- The top-level uart_cmd_rx instantiates uart_rx and holds the auth FSM.

## Test plan
All scenarios use BAUD_DIV=16 for speed, plus one smoke run at 2604.
- **Single byte:** send 8'hA5 -> rx_rdy rises 1 cycle after the stop sample, rx_data=8'hA5, frm_err stays 0, pwr_up stays 0.
- **Go then stop with rider off:** send 'g' -> pwr_up=1 1 cycle after rx_rdy. With rider_off=1, send 's' -> pwr_up=0.
- **Stop while rider on:** with pwr_up=1 and rider_off=0, send 's' -> pwr_up stays 1. Raise rider_off -> pwr_up=0 1 cycle later. Re-run, but send 'g' from PWR2 -> pwr_up stays 1, and a later rider_off has no effect.
- **Framing error:** send 8'h3C with the stop bit driven 0 -> frm_err pulses for exactly 1 cycle, rx_rdy stays 0, rx_data keeps its prior value.
- **Glitch and back-to-back:** a 3-cycle low pulse on RX -> no rx_rdy. Then 'g' followed immediately by 's' with no gap -> both decoded, and rx_data='s' at the end.
- **Reset mid-frame:** assert rst during data bit 4 -> all outputs 0 immediately. After release, a complete 8'h67 frame -> pwr_up=1.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared command codes, defaults and state encodings for the command receiver
package uart_cmd_pkg;
   localparam int         DEF_BAUD_DIV = 2604;
   localparam logic [7:0] DEF_CMD_GO   = 8'h67;
   localparam logic [7:0] DEF_CMD_STOP = 8'h73;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserializer with input synchronizer, sticky ready flag and framing-error pulse
module uart_rx
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   input  logic       clr_rdy_i,
   output logic [7:0] rx_data_o,
   output logic       rx_rdy_o,
   output logic       frm_err_o,
   output logic       vld_o
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
   logic            meta_q, sync_q, prev_q;
   rx_state_t       state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d, data_q;
   logic            rdy_q, ferr_q, vld_q;
   logic            baud_zero, start_det, ok, bad;
   assign baud_zero = baud_q == '0;
   assign start_det = state_q == IDLE && prev_q && !sync_q;
   // next state: half-bit wait to the start-bit centre, then full-bit strides to each sample
   always_comb begin
      state_d = state_q;
      baud_d  = baud_zero ? baud_q : baud_q - 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      ok      = 1'b0;
      bad     = 1'b0;
      unique case (state_q)
         IDLE: if (start_det) begin
            state_d = START;
            baud_d  = HALF_M1;
         end
         START: if (baud_zero) begin
            state_d = sync_q ? IDLE : DATA;
            baud_d  = FULL_M1;
            bit_d   = '0;
         end
         DATA: if (baud_zero) begin
            shift_d = {sync_q, shift_q[7:1]};
            bit_d   = bit_q + 4'd1;
            baud_d  = FULL_M1;
            state_d = bit_q == 4'd7 ? STOP : DATA;
         end
         STOP: if (baud_zero) begin
            state_d = IDLE;
            baud_d  = FULL_M1;
            ok      = sync_q;
            bad     = !sync_q;
         end
      endcase
   end
   // registers: synchronizer resets to idle-high so reset never fakes a start edge; set beats clear on rx_rdy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         meta_q  <= rx_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= ok ? shift_q : data_q;
         rdy_q   <= ok | (rdy_q & ~(clr_rdy_i | start_det));
         ferr_q  <= bad;
         vld_q   <= ok;
      end
   end
   assign rx_data_o = data_q;
   assign rx_rdy_o  = rdy_q;
   assign frm_err_o = ferr_q;
   assign vld_o     = vld_q;
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART command receiver decoding go/stop bytes into a rider-aware power enable
module uart_cmd_rx
   import uart_cmd_pkg::*;
#(
   parameter int         BAUD_DIV = DEF_BAUD_DIV,
   parameter logic [7:0] CMD_GO   = DEF_CMD_GO,
   parameter logic [7:0] CMD_STOP = DEF_CMD_STOP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       rider_off,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frm_err,
   output logic       pwr_up
);
   auth_state_t state_q, state_d;
   logic        vld, pwr_q;
   uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx_i      (RX),
      .clr_rdy_i (clr_rdy),
      .rx_data_o (rx_data),
      .rx_rdy_o  (rx_rdy),
      .frm_err_o (frm_err),
      .vld_o     (vld)
   );
   // authorization: a stop with a rider aboard parks in PWR2 until the rider steps off or go re-arms
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OFF:  if (vld && rx_data == CMD_GO) state_d = PWR1;
         PWR1: if (vld && rx_data == CMD_STOP) state_d = rider_off ? OFF : PWR2;
         PWR2: state_d = (vld && rx_data == CMD_GO) ? PWR1 : rider_off ? OFF : PWR2;
         default: state_d = OFF;
      endcase
   end
   // auth state and registered power enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OFF;
         pwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pwr_q   <= state_d != OFF;
      end
   end
   assign pwr_up = pwr_q;
endmodule
